axi_write_ctrl_burst: RTL
=========================

Name: axi_write_ctrl_burst

Overview:
Parametrised AXI4 write-channel to LINT/SRAM-port bridge for the L2 TCDM hybrid interconnect.
- Supports FIXED, INCR and WRAP bursts with address step 2^AWSIZE.
- Optional address-range decode.
- WLAST and protocol error detection with W-beat draining.
- B-response queue of configurable depth, so a new AW is accepted while earlier responses wait for BREADY.

Parameters:
AXI4_ADDRESS_WIDTH, 32, AW address width
AXI4_WDATA_WIDTH, 64, W data width; power of 2, >=8
AXI4_ID_WIDTH, 16, ID width
AXI4_USER_WIDTH, 10, user width
AXI_NUMBYTES, AXI4_WDATA_WIDTH/8, strobe width
MEM_ADDR_WIDTH, 13, byte-address width of memory port
CHECK_RANGE, 0, 1 enables decode check
MEM_BASE, 0, required value of AWADDR_i[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH] when CHECK_RANGE=1
B_FIFO_DEPTH, 2, B response queue entries; >=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
AWID_i, AWADDR_i, AWLEN_i[8], AWSIZE_i[3], AWBURST_i[2], AWUSER_i, AWVALID_i  in  AW channel
AWREADY_o  out  1  AW ready
WDATA_i, WSTRB_i, WLAST_i, WVALID_i  in  W channel
WREADY_o  out  1  W ready
BID_o, BRESP_o[2], BUSER_o, BVALID_o  out  B channel
BREADY_i  in  1  B ready
MEM_CEN_o  out  1  chip enable, active low
MEM_WEN_o  out  1  write enable, constant 0 (write)
MEM_A_o  out  MEM_ADDR_WIDTH  byte address
MEM_D_o  out  AXI4_WDATA_WIDTH  =WDATA_i
MEM_BE_o  out  AXI_NUMBYTES  =WSTRB_i
MEM_size_o  out  1  1 when AWSIZE=3
valid_o  out  1  request valid
grant_i  in  1  request granted
error_prot_i  in  1  memory error on granted beat

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state IDLE, queue empty, registers 0.
  - BVALID_o=0, WREADY_o=0, valid_o=0, MEM_CEN_o=1, AWREADY_o=1.
  - Reset mid-burst discards the burst and all queued responses.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - AWREADY_o = (queue count < B_FIFO_DEPTH).
  - AW handshake registers ID, USER, LEN, SIZE, BURST and addr[MEM_ADDR_WIDTH-1:0]; beat counter is cleared.
  - A burst with any of the following goes to DRAIN with the given response; otherwise BURST:
    - CHECK_RANGE=1 and upper address bits != MEM_BASE -> DECERR.
    - 2^AWSIZE > AXI_NUMBYTES, AWBURST=3, or WRAP with AWLEN not in {1,3,7,15} -> SLVERR.
  - WREADY_o=0 in IDLE. The first memory access occurs the cycle after the AW handshake.
- BURST:
  - valid_o=WVALID_i; WREADY_o=grant_i; MEM_CEN_o=~(WVALID_i&grant_i).
  - A beat is accepted when WVALID_i&grant_i.
  - MEM_A_o = current address; MEM_size_o = (SIZE==3).
  - Address update per accepted beat:
    - FIXED: unchanged.
    - INCR: addr + 2^SIZE, modulo 2^MEM_ADDR_WIDTH.
    - WRAP: addr = (addr & ~M) | ((addr + 2^SIZE) & M), where M = ((LEN+1)<<SIZE)-1.
  - WSTRB passes unmodified.
  - error_prot_i is sampled on accepted beats; if set, the sticky error flag is set.
  - Last expected beat (counter==LEN):
    - With WLAST_i=1: push a response (OKAY, or SLVERR if sticky) and go to IDLE.
    - With WLAST_i=0: go to DRAIN and mark SLVERR.
  - Early WLAST_i=1 (counter<LEN): the beat is written, then push SLVERR and go to IDLE.
  - Counter is 8 bits; LEN=255 gives 256 beats.
- DRAIN:
  - WREADY_o=1, valid_o=0, MEM_CEN_o=1.
  - Beats are sunk until the one with WLAST_i=1; then push the recorded error response and go to IDLE.
- B queue:
  - Entries hold {ID, USER, RESP}; BVALID_o = !empty; head drives BID_o/BUSER_o/BRESP_o.
  - Pop on BVALID_o&BREADY_i. Simultaneous push and pop keeps the count unchanged.
  - No push when full is impossible, because AW is gated by the count.
  - Head outputs are stable while BVALID_o=1 and BREADY_i=0.
- Combinational paths: grant_i->WREADY_o and WVALID_i->valid_o/MEM_CEN_o. There is no AW->W combinational path.

Test Plan:
- INCR: AWADDR=0x100, LEN=3, SIZE=3, W always valid, grant=1 -> MEM_A 0x100,0x108,0x110,0x118 on consecutive cycles; one B OKAY with matching ID/USER.
- WRAP: AWADDR=0x118, LEN=3, SIZE=3 -> MEM_A 0x118,0x100,0x108,0x110. FIXED: AWADDR=0x40, LEN=2 -> 0x40 x3.
- Missing WLAST on the 4th of 4 beats, WLAST on a 6th extra beat -> 4 memory writes, 2 drained beats with MEM_CEN=1, single B SLVERR. Early WLAST on beat 2 of 4 -> 2 writes, SLVERR.
- CHECK_RANGE=1, MEM_BASE=0, AWADDR=0x0001_0000, LEN=1 -> no memory access, 2 beats sunk, BRESP=DECERR. SIZE=4 on a 64-bit bus -> SLVERR.
- B_FIFO_DEPTH=2, BREADY=0, three single-beat writes -> two B entries queued, AWREADY=0 for the third. Then BREADY=1 -> B in order, the third AW is accepted the cycle after the first pop.
- grant toggling 1010, error_prot_i=1 on beat 2 -> no beat lost, address advances only on granted beats, BRESP=SLVERR. Reset asserted mid-burst -> BVALID=0, AWREADY=1 after release.

Source files
------------

// File: rtl/axi_write_ctrl_burst.sv
// AXI4 write channel to LINT/SRAM port bridge: FIXED/INCR/WRAP bursts, decode and
// protocol error handling with W draining, and a B-response queue decoupling AW from BREADY.
module axi_write_ctrl_burst #(
    parameter int unsigned                   AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned                   AXI4_WDATA_WIDTH   = 64,
    parameter int unsigned                   AXI4_ID_WIDTH      = 16,
    parameter int unsigned                   AXI4_USER_WIDTH    = 10,
    parameter int unsigned                   AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int unsigned                   MEM_ADDR_WIDTH     = 13,
    parameter bit                            CHECK_RANGE        = 1'b0,
    parameter logic [AXI4_ADDRESS_WIDTH-1:0] MEM_BASE           = '0,
    parameter int unsigned                   B_FIFO_DEPTH       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
    input  logic [7:0]                    AWLEN_i,
    input  logic [2:0]                    AWSIZE_i,
    input  logic [1:0]                    AWBURST_i,
    input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
    input  logic                          AWVALID_i,
    output logic                          AWREADY_o,
    input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
    input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
    input  logic                          WLAST_i,
    input  logic                          WVALID_i,
    output logic                          WREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]      BID_o,
    output logic [1:0]                    BRESP_o,
    output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
    output logic                          BVALID_o,
    input  logic                          BREADY_i,
    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
    output logic                          MEM_size_o,
    output logic                          valid_o,
    input  logic                          grant_i,
    input  logic                          error_prot_i
);

    localparam int unsigned SIZE_MAX = $clog2(AXI_NUMBYTES);
    localparam int unsigned UPPER_W  = AXI4_ADDRESS_WIDTH - MEM_ADDR_WIDTH;
    localparam int unsigned PTR_W    = (B_FIFO_DEPTH > 1) ? $clog2(B_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(B_FIFO_DEPTH + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [MEM_ADDR_WIDTH-1:0] maddr_t;

    typedef struct packed {
        logic [AXI4_ID_WIDTH-1:0]   id;
        logic [AXI4_USER_WIDTH-1:0] user;
        logic [1:0]                 resp;
    } b_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    maddr_t                     addr_q, addr_next, step, wrap_mask;
    logic [7:0]                 len_q, beat_q;
    logic [2:0]                 size_q;
    logic [1:0]                 burst_q, drain_resp_q, push_resp;
    logic [AXI4_ID_WIDTH-1:0]   id_q;
    logic [AXI4_USER_WIDTH-1:0] user_q;
    logic                       err_q;
    logic                       aw_ready, aw_hs, w_ready, mem_valid, beat_acc, push, pop;
    logic                       range_err, cfg_err, wrap_len_ok;

    b_entry_t                   b_mem [B_FIFO_DEPTH];
    b_entry_t                   push_entry, head;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;

    // AW legality, decided at the handshake
    assign wrap_len_ok = (AWLEN_i == 8'd1) || (AWLEN_i == 8'd3) ||
                         (AWLEN_i == 8'd7) || (AWLEN_i == 8'd15);
    assign cfg_err     = (AWSIZE_i > 3'(SIZE_MAX)) || (AWBURST_i == 2'b11) ||
                         ((AWBURST_i == BURST_WRAP) && !wrap_len_ok);
    assign range_err   = CHECK_RANGE &&
                         (AWADDR_i[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH] != MEM_BASE[UPPER_W-1:0]);

    // next beat address; WRAP keeps the bits above the wrap window fixed
    assign step      = maddr_t'(1) << size_q;
    assign wrap_mask = ((maddr_t'(len_q) + maddr_t'(1)) << size_q) - maddr_t'(1);

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = addr_q + step;
            BURST_WRAP: addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    addr_next = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        mem_valid = 1'b0;
        beat_acc  = 1'b0;
        push      = 1'b0;
        push_resp = RESP_OKAY;
        case (state_q)
            IDLE: begin
                aw_ready = (count_q < CNT_W'(B_FIFO_DEPTH));
                if (AWVALID_i && aw_ready) state_d = (range_err || cfg_err) ? DRAIN : BURST;
            end
            BURST: begin
                mem_valid = WVALID_i;
                w_ready   = grant_i;
                beat_acc  = WVALID_i & grant_i;
                if (beat_acc) begin
                    if (WLAST_i) begin
                        push      = 1'b1;
                        push_resp = (err_q || error_prot_i || (beat_q != len_q)) ? RESP_SLVERR : RESP_OKAY;
                        state_d   = IDLE;
                    end else if (beat_q == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_ready = 1'b1;
                if (WVALID_i && WLAST_i) begin
                    push      = 1'b1;
                    push_resp = drain_resp_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_hs = AWVALID_i & aw_ready;

    // burst context and per-beat address/counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            id_q         <= '0;
            user_q       <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            drain_resp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            addr_q       <= AWADDR_i[MEM_ADDR_WIDTH-1:0];
            len_q        <= AWLEN_i;
            size_q       <= AWSIZE_i;
            burst_q      <= AWBURST_i;
            id_q         <= AWID_i;
            user_q       <= AWUSER_i;
            beat_q       <= '0;
            err_q        <= 1'b0;
            drain_resp_q <= range_err ? RESP_DECERR : RESP_SLVERR;
        end else if (beat_acc) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 8'd1;
            if (error_prot_i) err_q <= 1'b1;
            if (!WLAST_i && (beat_q == len_q)) drain_resp_q <= RESP_SLVERR;
        end
    end

    // B response queue; AW gating by count guarantees a push never meets a full queue
    assign push_entry = {id_q, user_q, push_resp};
    assign head       = b_mem[rd_ptr_q];
    assign pop        = BVALID_o & BREADY_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(B_FIFO_DEPTH); i++) b_mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                b_mem[wr_ptr_q] <= push_entry;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(B_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(B_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    assign AWREADY_o  = aw_ready;
    assign WREADY_o   = w_ready;
    assign valid_o    = mem_valid;
    assign MEM_CEN_o  = ~beat_acc;
    assign MEM_WEN_o  = 1'b0;
    assign MEM_A_o    = addr_q;
    assign MEM_D_o    = WDATA_i;
    assign MEM_BE_o   = WSTRB_i;
    assign MEM_size_o = (size_q == 3'd3);
    assign BVALID_o   = (count_q != '0);
    assign BID_o      = head.id;
    assign BUSER_o    = head.user;
    assign BRESP_o    = head.resp;

endmodule
